// File: rtl/adc_sample_feeder_if.sv
// Bus and sample-stream bundle for adc_sample_feeder.
// master: the side that drives the bus and the raw ADC samples (CPU / testbench).
// slave:  the feeder itself.
interface adc_sample_feeder_if;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic        write;
  logic        read;
  logic [31:0] Rdata;
  logic [15:0] adc_data;
  logic        adc_strobe;
  logic [15:0] ADC;
  logic        PushADC;
  logic        overflow_irq;

  modport master (
    output addr, Wdata, write, read, adc_data, adc_strobe,
    input  Rdata, ADC, PushADC, overflow_irq
  );

  modport slave (
    input  addr, Wdata, write, read, adc_data, adc_strobe,
    output Rdata, ADC, PushADC, overflow_irq
  );
endinterface

// File: rtl/adc_sample_feeder.sv
// adc_sample_feeder: conditions raw ADC samples (offset subtract, saturating
// power-of-2 gain), buffers them in a FIFO and feeds the correlators with
// single-cycle PushADC pulses spaced at least MIN_GAP clocks apart.
// Optional build macro FEED_DC_TRACK_EN: replaces the static offset register with
// a 24-bit DC-tracking accumulator whose upper 16 bits are the offset.
module adc_sample_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_GAP    = 6
) (
  input logic               clk,
  input logic               rst,
  adc_sample_feeder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP - 1);

  localparam logic [31:0] A_CTRL   = 32'hFE00_0000;
  localparam logic [31:0] A_OFFSET = 32'hFE00_0004;
  localparam logic [31:0] A_SHIFT  = 32'hFE00_0008;
  localparam logic [31:0] A_STATUS = 32'hFE00_000C;

  typedef enum logic {READY, GAP} gap_state_e;

  // register file
  logic        en_q;
  logic [3:0]  shift_q;
  logic        ovf_q;
  logic [15:0] drop_q;
  logic [15:0] offset_use;

  // stage 1
  logic        s1_vld;
  logic [15:0] s1_y;

  // fifo
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;

  // gap fsm
  gap_state_e    state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;

  // outputs
  logic        push_q;
  logic [15:0] adc_q;
  logic [31:0] rdata;

  logic wr_ctrl, wr_offset, wr_shift, wr_status;
  logic flush, accept, full, empty, pop, push_ok, drop, clr_status;

  assign wr_ctrl    = bus.write && (bus.addr == A_CTRL);
  assign wr_offset  = bus.write && (bus.addr == A_OFFSET);
  assign wr_shift   = bus.write && (bus.addr == A_SHIFT);
  assign wr_status  = bus.write && (bus.addr == A_STATUS);
  assign flush      = wr_ctrl && bus.Wdata[1];
  assign clr_status = wr_status && bus.Wdata[8];

  // A flush in the same cycle as a strobe discards the sample.
  assign accept = bus.adc_strobe && en_q && !flush;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && (state_q == READY) && !flush;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok = s1_vld && !flush && (!full || pop);
  assign drop    = s1_vld && !flush && !push_ok;

`ifdef FEED_DC_TRACK_EN
  logic signed [23:0] acc_q;
  logic signed [16:0] dc_err;
  assign offset_use = acc_q[23:8];
  assign dc_err     = {bus.adc_data[15], bus.adc_data} - {acc_q[23], acc_q[23:8]};

  // DC tracker: a bus write reloads it, otherwise it integrates each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc_q <= '0;
    else if (wr_offset) acc_q <= {bus.Wdata[15:0], 8'h00};
    else if (accept)    acc_q <= acc_q + {{7{dc_err[16]}}, dc_err};
  end
`else
  logic [15:0] offset_q;
  assign offset_use = offset_q;

  // Static offset register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            offset_q <= '0;
    else if (wr_offset) offset_q <= bus.Wdata[15:0];
  end
`endif

  // Control, gain and status registers; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (wr_ctrl)  en_q    <= bus.Wdata[0];
      if (wr_shift) shift_q <= bus.Wdata[3:0];
      if (drop)            ovf_q <= 1'b1;
      else if (clr_status) ovf_q <= 1'b0;
      if (clr_status)                      drop_q <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // Stage-1 arithmetic: 17-bit difference, shift clamped to 8, saturate to 16 bits.
  logic signed [16:0] diff;
  logic signed [24:0] wide;
  logic        [3:0]  sh;
  logic        [15:0] sat;
  always_comb begin
    diff = {bus.adc_data[15], bus.adc_data} - {offset_use[15], offset_use};
    sh   = (shift_q > 4'd8) ? 4'd8 : shift_q;
    wide = {{8{diff[16]}}, diff} <<< sh;
    if (wide > 25'sd32767)       sat = 16'h7FFF;
    else if (wide < -25'sd32768) sat = 16'h8000;
    else                         sat = wide[15:0];
  end

  // Stage-1 register; flush kills any pending sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_y   <= '0;
    end else begin
      s1_vld <= flush ? 1'b0 : accept;
      if (accept) s1_y <= sat;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s1_y;
  end

  // FIFO pointers and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Gap FSM state register; reset lands in READY with the counter complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= READY;
      cnt_q   <= GAP_MAX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gap FSM next state: a pop restarts the count, which then runs up to GAP_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = READY;
      cnt_d   = GAP_MAX;
    end else begin
      case (state_q)
        READY: if (pop) begin
          state_d = GAP;
          cnt_d   = '0;
        end
        GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_MAX - 1'b1) state_d = READY;
        end
        default: state_d = READY;
      endcase
    end
  end

  // Registered push outputs; ADC holds between pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q <= 1'b0;
      adc_q  <= '0;
    end else begin
      push_q <= pop;
      if (pop) adc_q <= mem[rd_ptr];
    end
  end

  // Combinational read mux, forced to 0 while in reset.
  always_comb begin
    rdata = '0;
    if (!rst && bus.read) begin
      case (bus.addr)
        A_CTRL:   rdata = {31'b0, en_q};
        A_OFFSET: rdata = {16'b0, offset_use};
        A_SHIFT:  rdata = {28'b0, shift_q};
        A_STATUS: rdata = {drop_q, 7'b0, ovf_q, 2'b0, 6'(level_q)};
        default:  rdata = '0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.Wdata[31:16]};

  assign bus.Rdata        = rdata;
  assign bus.ADC          = adc_q;
  assign bus.PushADC      = push_q;
  assign bus.overflow_irq = ovf_q;
endmodule

// File: tb/tb_adc_sample_feeder.sv
// Directed self-checking bench for adc_sample_feeder (FIFO_DEPTH=16, MIN_GAP=6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adc_sample_feeder;
  localparam logic [31:0] A_CTRL   = 32'hFE00_0000;
  localparam logic [31:0] A_OFFSET = 32'hFE00_0004;
  localparam logic [31:0] A_SHIFT  = 32'hFE00_0008;
  localparam logic [31:0] A_STATUS = 32'hFE00_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] rd;

  adc_sample_feeder_if bus();

  adc_sample_feeder #(.FIFO_DEPTH(16), .MIN_GAP(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive a write now; it takes effect at the next rising edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.Wdata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.read = 1'b1;
    #1 d = bus.Rdata;
    bus.read = 1'b0;
  endtask

  // One strobe, then watch up to 30 cycles for its push.
  task automatic send_wait(input logic [15:0] d, output logic got, output logic [15:0] v);
    got = 1'b0; v = '0;
    bus.adc_data = d; bus.adc_strobe = 1'b1;
    @(negedge clk);
    bus.adc_strobe = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!got && bus.PushADC) begin got = 1'b1; v = bus.ADC; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.addr = '0; bus.Wdata = '0; bus.write = 0; bus.read = 0;
    bus.adc_data = '0; bus.adc_strobe = 0;
    repeat (2) @(negedge clk);
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL rst_rdata_in_reset got=%h exp=0", rd); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.PushADC !== 1'b0) $display("FAIL rst_push got=%b exp=0", bus.PushADC); else n_pass++;
    n_chk++; if (bus.ADC !== 16'h0) $display("FAIL rst_adc got=%h exp=0", bus.ADC); else n_pass++;
    n_chk++; if (bus.overflow_irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", bus.overflow_irq); else n_pass++;
    bus_rd(A_CTRL, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL rst_ctrl got=%h exp=0", rd); else n_pass++;
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL rst_status got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_latency();
    bus_wr(A_CTRL, 32'h1);
    bus.adc_data = 16'h1234; bus.adc_strobe = 1'b1;      // cycle N
    @(negedge clk); bus.adc_strobe = 1'b0;               // N+1
    n_chk++; if (bus.PushADC !== 1'b0) $display("FAIL lat_n1 push got=%b exp=0", bus.PushADC); else n_pass++;
    @(negedge clk);                                      // N+2
    n_chk++; if (bus.PushADC !== 1'b0) $display("FAIL lat_n2 push got=%b exp=0", bus.PushADC); else n_pass++;
    @(negedge clk);                                      // N+3
    n_chk++; if (bus.PushADC !== 1'b1) $display("FAIL lat_n3 push got=%b exp=1", bus.PushADC); else n_pass++;
    n_chk++; if (bus.ADC !== 16'h1234) $display("FAIL lat_n3 adc got=%h exp=1234", bus.ADC); else n_pass++;
    @(negedge clk);                                      // N+4
    n_chk++; if (bus.PushADC !== 1'b0) $display("FAIL lat_single_pulse got=%b exp=0", bus.PushADC); else n_pass++;
    n_chk++; if (bus.ADC !== 16'h1234) $display("FAIL lat_adc_hold got=%h exp=1234", bus.ADC); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_gain();
    logic got; logic [15:0] v;
    bus_wr(A_OFFSET, 32'h0100);
    bus_wr(A_SHIFT, 32'h4);
    send_wait(16'h0800, got, v);
    n_chk++; if (!got || v !== 16'h7000) $display("FAIL gain_pos got=%h seen=%b exp=7000", v, got); else n_pass++;
    send_wait(16'hF000, got, v);
    n_chk++; if (!got || v !== 16'h8000) $display("FAIL gain_neg_sat got=%h seen=%b exp=8000", v, got); else n_pass++;
    bus_wr(A_OFFSET, 32'h0);
    bus_wr(A_SHIFT, 32'hF);
    send_wait(16'h0010, got, v);
    n_chk++; if (!got || v !== 16'h1000) $display("FAIL gain_shift_clamp got=%h seen=%b exp=1000", v, got); else n_pass++;
    bus_wr(A_SHIFT, 32'h9);
    send_wait(16'h0080, got, v);
    n_chk++; if (!got || v !== 16'h7FFF) $display("FAIL gain_pos_sat got=%h seen=%b exp=7fff", v, got); else n_pass++;
    bus_wr(A_SHIFT, 32'h0);
  endtask

  task automatic test_gap();
    logic [15:0] seen [8];
    int pc [8];
    int np = 0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 80; c++) begin
      if (bus.PushADC) begin
        if (np < 8) begin seen[np] = bus.ADC; pc[np] = c; end
        np++;
      end
      bus.adc_strobe = (c < 8);
      bus.adc_data   = 16'h1000 + 16'(c * 16'h0111);
      @(negedge clk);
    end
    bus.adc_strobe = 1'b0;
    n_chk++; if (np !== 8) $display("FAIL gap_count got=%0d exp=8", np); else n_pass++;
    if (np == 8) begin
      n_chk++; if (pc[0] !== 3) $display("FAIL gap_first got=%0d exp=3", pc[0]); else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (seen[i] !== 16'h1000 + 16'(i * 16'h0111))
          $display("FAIL gap_order[%0d] got=%h exp=%h", i, seen[i], 16'h1000 + 16'(i * 16'h0111));
        else n_pass++;
        if (i > 0) begin
          n_chk++;
          if (pc[i] - pc[i-1] !== 6) $display("FAIL gap_spacing[%0d] got=%0d exp=6", i, pc[i] - pc[i-1]);
          else n_pass++;
        end
      end
    end
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[31:16] !== 16'h0 || rd[8] !== 1'b0) $display("FAIL gap_no_drops got=%h exp drop=0 ovf=0", rd); else n_pass++;
  endtask

  task automatic test_overflow();
    int peak = 0;
    repeat (10) @(negedge clk);
    for (int c = 0; c < 46; c++) begin
      bus_rd(A_STATUS, rd);
      if (int'(rd[5:0]) > peak) peak = int'(rd[5:0]);
      bus.adc_strobe = (c < 40);
      bus.adc_data   = 16'(c);
      @(negedge clk);
    end
    bus.adc_strobe = 1'b0;
    bus_rd(A_STATUS, rd);
    n_chk++; if (peak !== 16) $display("FAIL ovf_peak got=%0d exp=16", peak); else n_pass++;
    n_chk++; if (rd[31:16] !== 16'd17) $display("FAIL ovf_drop_count got=%0d exp=17", rd[31:16]); else n_pass++;
    n_chk++; if (rd[8] !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", rd[8]); else n_pass++;
    n_chk++; if (bus.overflow_irq !== 1'b1) $display("FAIL ovf_irq got=%b exp=1", bus.overflow_irq); else n_pass++;
    bus_wr(A_STATUS, 32'h100);
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[8] !== 1'b0 || rd[31:16] !== 16'h0) $display("FAIL ovf_clear got=%h exp ovf=0 drop=0", rd); else n_pass++;
    n_chk++; if (bus.overflow_irq !== 1'b0) $display("FAIL ovf_irq_clear got=%b exp=0", bus.overflow_irq); else n_pass++;
    repeat (120) @(negedge clk);
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[5:0] !== 6'd0) $display("FAIL ovf_drain level got=%0d exp=0", rd[5:0]); else n_pass++;
  endtask

  task automatic test_flush();
    int pushes = 0;
    logic got; logic [15:0] v;
    for (int c = 0; c < 7; c++) begin
      bus.adc_strobe = (c < 6);
      bus.adc_data   = 16'h0020 + 16'(c);
      @(negedge clk);
    end
    bus.adc_strobe = 1'b0;
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[5:0] !== 6'd5) $display("FAIL flush_pre_level got=%0d exp=5", rd[5:0]); else n_pass++;
    bus_wr(A_CTRL, 32'h3);
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[5:0] !== 6'd0) $display("FAIL flush_level got=%0d exp=0", rd[5:0]); else n_pass++;
    bus_rd(A_CTRL, rd);
    n_chk++; if (rd !== 32'h1) $display("FAIL flush_ctrl_read got=%h exp=1", rd); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (bus.PushADC) pushes++;
      @(negedge clk);
    end
    n_chk++; if (pushes !== 0) $display("FAIL flush_no_push got=%0d exp=0", pushes); else n_pass++;
    // flush together with a strobe: the strobed sample is discarded
    bus.adc_data = 16'h0BAD; bus.adc_strobe = 1'b1;
    bus_wr(A_CTRL, 32'h3);
    bus.adc_strobe = 1'b0;
    pushes = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.PushADC) pushes++;
      @(negedge clk);
    end
    n_chk++; if (pushes !== 0) $display("FAIL flush_wins_strobe got=%0d exp=0", pushes); else n_pass++;
    send_wait(16'h0042, got, v);
    n_chk++; if (!got || v !== 16'h0042) $display("FAIL flush_recover got=%h seen=%b exp=0042", v, got); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    int pushes = 0;
    for (int c = 0; c < 4; c++) begin
      bus.adc_strobe = 1'b1; bus.adc_data = 16'h0300 + 16'(c);
      @(negedge clk);
    end
    bus.adc_strobe = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.PushADC) got = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!got) $display("FAIL rstmid_push_seen got=0 exp=1"); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.PushADC !== 1'b0) $display("FAIL rstmid_push_drop got=%b exp=0", bus.PushADC); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus_rd(A_STATUS, rd);
    n_chk++; if (rd[5:0] !== 6'd0) $display("FAIL rstmid_level got=%0d exp=0", rd[5:0]); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (bus.PushADC) pushes++;
      @(negedge clk);
    end
    n_chk++; if (pushes !== 0) $display("FAIL rstmid_no_push got=%0d exp=0", pushes); else n_pass++;
  endtask

`ifdef FEED_DC_TRACK_EN
  task automatic test_dc_track();
    int v;
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_OFFSET, 32'h0);
    bus_wr(A_SHIFT, 32'h0);
    bus.adc_data = 16'h0400; bus.adc_strobe = 1'b1;
    repeat (4000) @(negedge clk);
    bus.adc_strobe = 1'b0;
    repeat (200) @(negedge clk);
    v = int'($signed(bus.ADC));
    n_chk++; if (v < -2 || v > 2) $display("FAIL dc_converge got=%0d exp=-2..2", v); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_gain();
    test_gap();
    test_overflow();
    test_flush();
    test_reset_mid();
`ifdef FEED_DC_TRACK_EN
    test_dc_track();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
